// File: rtl/pid_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pid_update_scheduler
// Brief   : Sweeps one shared PID datapath across all motors once per period.
// Revision: 1.0 - initial release
// ============================================================================
module pid_update_scheduler #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int PERIOD_TICKS     = 500000,
  parameter int RESULT_LATENCY   = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable_i,
  input  logic [NUMBER_OF_MOTORS-1:0]      motor_enable_i,
  input  logic signed [31:0]               pid_result_i,
  output logic [3:0]                       motor_sel_o,
  output logic                             update_controller_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]   results_o,
  output logic                             sweep_done_o,
  output logic                             busy_o,
  output logic [15:0]                      overrun_count_o
);

  localparam int TIMER_W = $clog2(PERIOD_TICKS);
  localparam int WAIT_W  = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD_TICKS - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(RESULT_LATENCY - 1);
  localparam logic [3:0]         IDX_LAST   = 4'(NUMBER_OF_MOTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_PULSE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [3:0]          idx_q, idx_d;
  logic [15:0]         mask_q, mask_d;
  logic [15:0]         overrun_q, overrun_d;
  logic                update_q, done_q, busy_q;
  logic                tick;
  logic                last_motor;
  logic                slot_we;
  logic [31:0]         slot_wdata;

  // Period timer: the tick fires in the cycle the count wraps back to 0.
  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (!enable_i) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d = '0;
      tick    = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (tick && (state_q != S_IDLE) && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  assign last_motor = (idx_q == IDX_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    wait_d     = wait_q;
    slot_we    = 1'b0;
    slot_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          mask_d  = 16'(motor_enable_i);
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q[idx_q]) begin
          state_d = S_PULSE;
        end else begin
          // Disabled motors still get their slot cleared so no slot goes stale.
          slot_we = 1'b1;
          state_d = last_motor ? S_DONE : S_SELECT;
          idx_d   = last_motor ? idx_q : idx_q + 4'd1;
        end
      end
      S_PULSE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        slot_we    = 1'b1;
        slot_wdata = pid_result_i;
        state_d    = last_motor ? S_DONE : S_SELECT;
        idx_d      = last_motor ? idx_q : idx_q + 4'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      wait_q    <= '0;
      idx_q     <= '0;
      mask_q    <= '0;
      overrun_q <= '0;
      update_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      // Strobes are registered from the next state so they never glitch.
      update_q  <= (state_d == S_PULSE);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  for (genvar i = 0; i < NUMBER_OF_MOTORS; i++) begin : g_slot
    logic [31:0] slot_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        slot_q <= '0;
      end else if (slot_we && (idx_q == 4'(i))) begin
        slot_q <= slot_wdata;
      end
    end
    assign results_o[32*i +: 32] = slot_q;
  end

  assign motor_sel_o         = idx_q;
  assign update_controller_o = update_q;
  assign sweep_done_o        = done_q;
  assign busy_o              = busy_q;
  assign overrun_count_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pid_update_scheduler
// Brief   : Randomized self-checking bench with a tick-level sweep model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pid_update_scheduler;

  localparam int N = 6;
  localparam int P = 20;
  localparam int L = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            enable_i = 1'b0;
  logic [N-1:0]    motor_enable_i = '0;
  logic [31:0]     pid_result_i = '0;
  logic [3:0]      motor_sel_o;
  logic            update_controller_o;
  logic [32*N-1:0] results_o;
  logic            sweep_done_o;
  logic            busy_o;
  logic [15:0]     overrun_count_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int obs_rise[$];
  int obs_fall[$];
  int obs_done[$];
  int obs_pcyc[$];
  int obs_psel[$];
  logic [31:0] pid_val [N];

  pid_update_scheduler #(
    .NUMBER_OF_MOTORS(N),
    .PERIOD_TICKS    (P),
    .RESULT_LATENCY  (L)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .enable_i           (enable_i),
    .motor_enable_i     (motor_enable_i),
    .pid_result_i       (pid_result_i),
    .motor_sel_o        (motor_sel_o),
    .update_controller_o(update_controller_o),
    .results_o          (results_o),
    .sweep_done_o       (sweep_done_o),
    .busy_o             (busy_o),
    .overrun_count_o    (overrun_count_o)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // PID model plus event recorder: a fresh result appears L clks after the
  // update cycle and garbage is shown until then.
  initial begin
    int pend_cnt;
    logic [31:0] pend_val;
    bit prev_upd;
    bit prev_busy;
    pend_cnt = 0; pend_val = '0; prev_upd = 0; prev_busy = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend_cnt = 0; prev_upd = 0; prev_busy = 0;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) pid_result_i = pend_val;
        end
        if (update_controller_o) begin
          checks++;
          if (prev_upd) begin
            errors++;
            $display("FAIL upd_single cycle %0d: update high 2 clks in a row, required 1", cyc);
          end
          pend_val     = $urandom;
          pend_cnt     = L;
          pid_result_i = $urandom;
          if (int'(motor_sel_o) < N) pid_val[int'(motor_sel_o)] = pend_val;
          obs_pcyc.push_back(cyc);
          obs_psel.push_back(int'(motor_sel_o));
        end
        if (busy_o && !prev_busy) obs_rise.push_back(cyc);
        if (!busy_o && prev_busy) obs_fall.push_back(cyc);
        if (sweep_done_o) obs_done.push_back(cyc);
        prev_upd  = update_controller_o;
        prev_busy = busy_o;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy_o) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b after 200 clks, required 0", busy_o);
    end
    repeat (2) @(negedge clock);
  endtask

  // Runs enable from cycle k until a stop point, then compares everything seen
  // against a tick-by-tick model of sweeps and dropped ticks.
  task automatic run_sweeps(input string name, input logic [N-1:0] mask,
                            input bit scramble, input int hold);
    int k, stop, n, t, last_done, s, ov, ov0;
    int rb, fb, db, pb;
    int er[$];
    int ed[$];
    int epc[$];
    int eps[$];
    logic [31:0] exp_slot;
    rb = obs_rise.size(); fb = obs_fall.size(); db = obs_done.size(); pb = obs_pcyc.size();
    ov0 = int'(overrun_count_o);
    motor_enable_i = mask;
    enable_i = 1'b1;
    k = cyc;
    n = 0;
    if (hold == 0) begin
      while (n < 400) begin
        @(negedge clock);
        n++;
        if (scramble && busy_o) motor_enable_i = N'($urandom);
        if (sweep_done_o) break;
      end
      checks++;
      if (!sweep_done_o) begin
        errors++;
        $display("FAIL %s done_timeout: sweep_done=%0b after %0d clks, required 1", name, sweep_done_o, n);
      end
    end else begin
      repeat (hold) @(negedge clock);
    end
    stop = cyc;
    enable_i = 1'b0;
    drain();

    ov = 0;
    last_done = -1;
    for (t = k + P - 1; t < stop; t += P) begin
      if (t > last_done) begin
        s = t + 1;
        er.push_back(s);
        for (int i = 0; i < N; i++) begin
          if (mask[i]) begin
            epc.push_back(s + 1);
            eps.push_back(i);
            s += 3 + L;
          end else begin
            s += 1;
          end
        end
        ed.push_back(s);
        last_done = s;
      end else begin
        ov++;
      end
    end

    checks++;
    if (obs_rise.size() - rb != er.size())
      begin errors++; $display("FAIL %s sweep_count: %0d sweeps, required %0d", name, obs_rise.size() - rb, er.size()); end
    for (int j = 0; j < er.size() && rb + j < obs_rise.size(); j++) begin
      checks++;
      if (obs_rise[rb+j] != er[j])
        begin errors++; $display("FAIL %s busy_rise%0d: cycle %0d, required %0d", name, j, obs_rise[rb+j], er[j]); end
    end
    for (int j = 0; j < ed.size(); j++) begin
      checks++;
      if (db + j >= obs_done.size() || obs_done[db+j] != ed[j])
        begin errors++; $display("FAIL %s done%0d: cycle %0d, required %0d", name, j,
                                 (db + j < obs_done.size()) ? obs_done[db+j] : -1, ed[j]); end
      checks++;
      if (fb + j >= obs_fall.size() || obs_fall[fb+j] != ed[j] + 1)
        begin errors++; $display("FAIL %s busy_fall%0d: cycle %0d, required %0d", name, j,
                                 (fb + j < obs_fall.size()) ? obs_fall[fb+j] : -1, ed[j] + 1); end
    end
    checks++;
    if (obs_done.size() - db != ed.size())
      begin errors++; $display("FAIL %s done_count: %0d, required %0d", name, obs_done.size() - db, ed.size()); end
    checks++;
    if (obs_pcyc.size() - pb != epc.size())
      begin errors++; $display("FAIL %s pulse_count: %0d, required %0d", name, obs_pcyc.size() - pb, epc.size()); end
    for (int j = 0; j < epc.size() && pb + j < obs_pcyc.size(); j++) begin
      checks++;
      if (obs_pcyc[pb+j] != epc[j] || obs_psel[pb+j] != eps[j])
        begin errors++; $display("FAIL %s pulse%0d: cycle %0d sel %0d, required cycle %0d sel %0d",
                                 name, j, obs_pcyc[pb+j], obs_psel[pb+j], epc[j], eps[j]); end
    end
    for (int i = 0; i < N; i++) begin
      exp_slot = mask[i] ? pid_val[i] : 32'h0;
      checks++;
      if (results_o[32*i +: 32] !== exp_slot)
        begin errors++; $display("FAIL %s slot%0d: %h, required %h", name, i, results_o[32*i +: 32], exp_slot); end
    end
    checks++;
    if (int'(overrun_count_o) - ov0 != ov)
      begin errors++; $display("FAIL %s overrun_delta: %0d, required %0d", name, int'(overrun_count_o) - ov0, ov); end
  endtask

  task automatic test_reset();
    checks++; if (motor_sel_o !== 4'd0) begin errors++; $display("FAIL rst_sel: %0d, required 0", motor_sel_o); end
    checks++; if (update_controller_o !== 1'b0) begin errors++; $display("FAIL rst_upd: %b, required 0", update_controller_o); end
    checks++; if (results_o !== '0) begin errors++; $display("FAIL rst_results: %h, required 0", results_o); end
    checks++; if (sweep_done_o !== 1'b0) begin errors++; $display("FAIL rst_done: %b, required 0", sweep_done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy_o); end
    checks++; if (overrun_count_o !== 16'd0) begin errors++; $display("FAIL rst_overrun: %0d, required 0", overrun_count_o); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_full_mask();
    int rb;
    rb = obs_rise.size();
    run_sweeps("full", 6'h3F, 1'b0, 0);
    checks++;
    if (obs_rise.size() > rb && obs_fall.size() > 0 && obs_fall[obs_fall.size()-1] - obs_rise[rb] != 31)
      begin errors++; $display("FAIL full_busy_len: %0d clks, required 31", obs_fall[obs_fall.size()-1] - obs_rise[rb]); end
  endtask

  task automatic test_partial_mask();
    run_sweeps("partial", 6'b000101, 1'b0, 0);
  endtask

  task automatic test_zero_mask();
    run_sweeps("zero", 6'h00, 1'b0, 0);
  endtask

  task automatic test_random_masks();
    for (int r = 0; r < 6; r++) run_sweeps("random", N'($urandom), 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_sweeps("b2b_full", 6'h3F, 1'b0, 170);
    run_sweeps("b2b_mixed", 6'b110110, 1'b0, 130);
  endtask

  task automatic test_enable_hold();
    int pb, rb;
    pb = obs_pcyc.size(); rb = obs_rise.size();
    enable_i = 1'b0;
    motor_enable_i = '1;
    repeat (3*P) @(negedge clock);
    checks++; if (obs_pcyc.size() != pb) begin errors++; $display("FAIL hold_pulses: %0d, required 0", obs_pcyc.size() - pb); end
    checks++; if (obs_rise.size() != rb) begin errors++; $display("FAIL hold_sweeps: %0d, required 0", obs_rise.size() - rb); end
    run_sweeps("reenable", 6'h3F, 1'b0, 0);
  endtask

  task automatic test_reset_midsweep();
    int n, db;
    bit found;
    n = 0; found = 0;
    motor_enable_i = '1;
    enable_i = 1'b1;
    while (!found && n < 400) begin
      @(negedge clock);
      n++;
      if (update_controller_o && motor_sel_o == 4'd3) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_find: motor-3 pulse seen=%0b, required 1", found); end
    reset = 1'b1;
    enable_i = 1'b0;
    @(negedge clock);
    checks++; if (update_controller_o !== 1'b0) begin errors++; $display("FAIL midrst_upd: %b, required 0", update_controller_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: %b, required 0", busy_o); end
    checks++; if (results_o !== '0) begin errors++; $display("FAIL midrst_results: %h, required 0", results_o); end
    checks++; if (overrun_count_o !== 16'd0) begin errors++; $display("FAIL midrst_overrun: %0d, required 0", overrun_count_o); end
    checks++; if (motor_sel_o !== 4'd0) begin errors++; $display("FAIL midrst_sel: %0d, required 0", motor_sel_o); end
    db = obs_done.size();
    reset = 1'b0;
    repeat (3*P) @(negedge clock);
    checks++; if (obs_done.size() != db) begin errors++; $display("FAIL midrst_done: %0d pulses, required 0", obs_done.size() - db); end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    test_full_mask();
    test_partial_mask();
    test_zero_mask();
    test_random_masks();
    test_back_to_back();
    test_enable_hold();
    test_reset_midsweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
